// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding imem
// requests, holds the fetched word in the IF slot and advances it into IF/ID.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             imem_req_o,
    output logic [31:0]      imem_addr_o,
    input  logic             imem_rvalid_i,
    input  logic [31:0]      imem_rdata_i,
    input  logic             stall_i,
    input  logic             hit_i,
    input  logic [31:0]      npc_i,
    input  logic             flush_br_i,
    output logic [31:0]      pc_IF_o,
    output logic [31:0]      instr_IF_o,
    output logic             valid_IF_o,
    output logic [31:0]      pc_ID_o,
    output logic [31:0]      instr_ID_o,
    output logic             valid_ID_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic               if_valid_q, if_valid_d;
    logic [31:0]        if_pc_q, if_pc_d;
    logic [31:0]        if_instr_q, if_instr_d;
    logic               id_valid_q, id_valid_d;
    logic [31:0]        id_pc_q, id_pc_d;
    logic [31:0]        id_instr_q, id_instr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               advance;
    logic [31:0]        next_pc;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= '0;
            id_valid_q <= 1'b0;
            id_pc_q    <= '0;
            id_instr_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;
        cnt_d      = cnt_q;
        next_pc    = hit_i ? npc_i : (if_pc_q + 32'd4);
        advance    = (state_q == S_HOLD) && !stall_i && !flush_br_i;

        unique case (state_q)
            S_REQ:  state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i && !flush_br_i) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem_rdata_i;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (advance) begin
                    id_pc_d    = if_pc_q;
                    id_instr_d = if_instr_q;
                    if_valid_d = 1'b0;
                    pc_d       = next_pc;
                    state_d    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid_i) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase

        if (advance)       id_valid_d = 1'b1;
        else if (!stall_i) id_valid_d = 1'b0;

        // Flush overrides stall and advance; an outstanding response must still drain.
        if (flush_br_i) begin
            if_valid_d = 1'b0;
            id_valid_d = 1'b0;
            pc_d       = npc_i;
            cnt_d      = cnt_q + CNT_W'(1);
            if (state_q == S_WAIT || state_q == S_DROP)
                state_d = imem_rvalid_i ? S_REQ : S_DROP;
            else
                state_d = S_REQ;
        end
    end

    assign imem_req_o     = (state_q == S_REQ) && !rst_i;
    assign imem_addr_o    = imem_req_o ? pc_q : '0;
    assign pc_IF_o        = if_pc_q;
    assign instr_IF_o     = if_instr_q;
    assign valid_IF_o     = if_valid_q;
    assign pc_ID_o        = id_pc_q;
    assign instr_ID_o     = id_instr_q;
    assign valid_ID_o     = id_valid_q;
    assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: cycle-by-cycle expectations against a
// latency-programmable memory model, plus a second instance for PC wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        req;
    logic [31:0] addr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall, hit, flush;
    logic [31:0] npc;
    logic [31:0] pc_if, instr_if, pc_id, instr_id, cnt;
    logic        valid_if, valid_id;

    logic        req2;
    logic [31:0] addr2;
    logic        rvalid2;
    logic [31:0] pc_if2, instr_if2, pc_id2, instr_id2, cnt2;
    logic        valid_if2, valid_id2;
    logic        zero;

    int unsigned lat;
    int unsigned mcnt;
    logic [31:0] mem_word;
    int          n_checks;
    int          n_fail;

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req), .imem_addr_o(addr),
        .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
        .stall_i(stall), .hit_i(hit), .npc_i(npc), .flush_br_i(flush),
        .pc_IF_o(pc_if), .instr_IF_o(instr_if), .valid_IF_o(valid_if),
        .pc_ID_o(pc_id), .instr_ID_o(instr_id), .valid_ID_o(valid_id),
        .redirect_cnt_o(cnt)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(32)) dut_wrap (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(req2), .imem_addr_o(addr2),
        .imem_rvalid_i(rvalid2), .imem_rdata_i(32'h0000_0013),
        .stall_i(zero), .hit_i(zero), .npc_i(32'h0), .flush_br_i(zero),
        .pc_IF_o(pc_if2), .instr_IF_o(instr_if2), .valid_IF_o(valid_if2),
        .pc_ID_o(pc_id2), .instr_ID_o(instr_id2), .valid_ID_o(valid_id2),
        .redirect_cnt_o(cnt2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-cycle memory for the wrap instance.
    always_ff @(posedge clk) rvalid2 <= req2 && !rst;

    // Main memory: request seen before the edge, response lat edges later.
    initial begin
        rvalid = 1'b0;
        rdata  = '0;
        mcnt   = 0;
        forever begin
            @(negedge clk);
            #3;
            if (req && !rst) mcnt = lat;
            @(posedge clk);
            #1;
            rvalid = 1'b0;
            if (rst) mcnt = 0;
            else if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    rvalid = 1'b1;
                    rdata  = mem_word;
                end
            end
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        zero     = 1'b0;
        rst      = 1'b1;
        stall    = 1'b0;
        hit      = 1'b0;
        flush    = 1'b0;
        npc      = '0;
        lat      = 1;
        mem_word = 32'h0000_0013;

        cyc(); cyc();
        chk("rst_req", req, 0);
        chk("rst_valid_if", valid_if, 0);
        chk("rst_valid_id", valid_id, 0);
        chk("rst_pc_if", pc_if, 0);
        chk("rst_pc_id", pc_id, 0);
        chk("rst_instr_id", instr_id, 0);
        chk("rst_cnt", cnt, 0);

        rst = 1'b0;
        #1;
        chk("c0_req", req, 1);
        chk("c0_addr", addr, 32'h0);
        chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
        cyc();
        chk("c1_req", req, 0);
        chk("c1_addr", addr, 32'h0);
        cyc();
        chk("c2_valid_if", valid_if, 1);
        chk("c2_pc_if", pc_if, 32'h0);
        chk("c2_instr_if", instr_if, 32'h13);
        cyc();
        chk("c3_addr", addr, 32'h4);
        chk("c3_valid_id", valid_id, 1);
        chk("c3_pc_id", pc_id, 32'h0);
        chk("wrap_second_req", req2, 1);
        chk("wrap_second_addr", addr2, 32'h0);
        cyc();
        chk("c4_bubble", valid_id, 0);
        cyc(); cyc();
        chk("c6_addr", addr, 32'h8);
        chk("c6_pc_id", pc_id, 32'h4);
        chk("c6_valid_id", valid_id, 1);
        cyc(); cyc(); cyc();
        chk("c9_addr", addr, 32'hC);
        chk("c9_pc_id", pc_id, 32'h8);
        chk("c9_cnt", cnt, 0);

        // Branch fetched at 0xC, predicted taken to 0x100.
        mem_word = 32'h0000_0063;
        cyc(); cyc();
        chk("c11_pc_if", pc_if, 32'hC);
        chk("c11_instr_if", instr_if, 32'h63);
        hit = 1'b1;
        npc = 32'h100;
        cyc();
        chk("br_addr", addr, 32'h100);
        chk("br_pc_id", pc_id, 32'hC);
        chk("br_instr_id", instr_id, 32'h63);
        chk("br_valid_id", valid_id, 1);
        mem_word = 32'h0000_0013;
        npc = 32'h500;
        cyc();

        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid_if", valid_if, 1);
            chk("stall_pc_if", pc_if, 32'h100);
            chk("stall_req", req, 0);
            chk("stall_pc_id", pc_id, 32'hC);
            chk("stall_instr_id", instr_id, 32'h63);
            hit   = 1'b0;
            stall = 1'b1;
        end
        cyc();
        chk("c19_held_valid_if", valid_if, 1);
        chk("c19_req", req, 0);
        stall = 1'b0;
        cyc();
        chk("c20_addr", addr, 32'h104);
        chk("c20_pc_id", pc_id, 32'h100);
        chk("c20_valid_id", valid_id, 1);

        // Flush while waiting on a 3-cycle response.
        lat = 3;
        cyc();
        chk("c21_req", req, 0);
        flush = 1'b1;
        npc   = 32'h200;
        cyc();
        chk("fw_req", req, 0);
        chk("fw_valid_if", valid_if, 0);
        chk("fw_valid_id", valid_id, 0);
        chk("fw_cnt", cnt, 1);
        flush = 1'b0;
        cyc();
        chk("drop_req", req, 0);
        cyc();
        chk("fw_next_addr", addr, 32'h200);
        chk("fw_req2", req, 1);
        chk("drop_valid_if", valid_if, 0);
        lat = 1;
        cyc(); cyc();
        chk("c26_pc_if", pc_if, 32'h200);
        chk("c26_valid_if", valid_if, 1);

        // Flush and stall together in S_HOLD.
        stall = 1'b1;
        flush = 1'b1;
        npc   = 32'h300;
        cyc();
        chk("fs_addr", addr, 32'h300);
        chk("fs_valid_if", valid_if, 0);
        chk("fs_valid_id", valid_id, 0);
        chk("fs_cnt", cnt, 2);
        chk("fs_pc_id", pc_id, 32'h100);
        flush = 1'b0;
        stall = 1'b0;
        cyc(); cyc(); cyc();
        chk("c30_addr", addr, 32'h304);
        chk("c30_pc_id", pc_id, 32'h300);

        // Flush in S_WAIT coinciding with the response.
        cyc();
        flush = 1'b1;
        npc   = 32'h400;
        cyc();
        chk("fr_addr", addr, 32'h400);
        chk("fr_valid_if", valid_if, 0);
        chk("fr_cnt", cnt, 3);
        flush = 1'b0;
        cyc(); cyc();
        chk("c34_pc_if", pc_if, 32'h400);
        cyc();
        chk("c35_addr", addr, 32'h404);
        chk("c35_pc_id", pc_id, 32'h400);

        // Reset in the middle of S_WAIT.
        lat = 3;
        cyc();
        chk("c36_req", req, 0);
        rst = 1'b1;
        cyc();
        chk("mr_valid_if", valid_if, 0);
        chk("mr_valid_id", valid_id, 0);
        chk("mr_cnt", cnt, 0);
        chk("mr_req", req, 0);
        rst = 1'b0;
        #1;
        chk("mr_next_req", req, 1);
        chk("mr_next_addr", addr, 32'h0);
        chk("mr_wrap_addr", addr2, 32'hFFFF_FFFC);
        cyc(); cyc(); cyc();
        chk("mr_wrap_second_addr", addr2, 32'h0);
        chk("mr_slow_req", req, 0);
        cyc();
        chk("mr_slow_valid_if", valid_if, 1);
        chk("mr_slow_pc_if", pc_if, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
